// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron datapath.
//   I_WIDTH     : signed width of every current value (input_current of the neuron)
//   W_WIDTH     : signed width of a synaptic weight
//   izh_state_e : sequencing states of the synaptic-current stage
//   sat_i()     : clamps a wide signed value into a given signed width and
//                 reports whether a clamp happened
package izh_pkg;

  localparam int I_WIDTH = 16;
  localparam int W_WIDTH = 8;

  // Working width for the saturation helper; any sum handed to it is first
  // sign-extended to this width.
  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    DECAY,
    ACCUM,
    OUTPUT
  } izh_state_e;

  // Clamp 'value' into [-2^(width-1), 2^(width-1)-1]; 'clamped' goes high when
  // the input lay outside that range. The caller truncates the result to 'width'.
  function automatic logic signed [SAT_W-1:0] sat_i(
    input  logic signed [SAT_W-1:0] value,
    input  int                      width,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] maxV;
    logic signed [SAT_W-1:0] minV;
    maxV    = (32'sd1 <<< (width - 1)) - 32'sd1;
    minV    = -maxV - 32'sd1;
    clamped = 1'b0;
    sat_i   = value;
    if (value > maxV) begin
      sat_i   = maxV;
      clamped = 1'b1;
    end else if (value < minV) begin
      sat_i   = minV;
      clamped = 1'b1;
    end
  endfunction

endpackage

// File: rtl/izh_weight_rf.sv
// Synaptic weight register file.
//   clk, reset        : rising-edge clock, synchronous active-high reset (clears all weights)
//   wr_en_i           : write strobe; the write lands at the clock edge
//   wr_addr_i         : write index; indices at or above N_SYN are ignored
//   wr_data_i         : signed weight to store
//   rd_addr_i         : asynchronous read index
//   rd_data_o         : weight at rd_addr_i (old value during a same-index write)
module izh_weight_rf
  import izh_pkg::*;
#(
  parameter int N_SYN   = 8,
  parameter int W_WIDTH = izh_pkg::W_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [$clog2(N_SYN)-1:0]   wr_addr_i,
  input  logic signed [W_WIDTH-1:0]  wr_data_i,
  input  logic [$clog2(N_SYN)-1:0]   rd_addr_i,
  output logic signed [W_WIDTH-1:0]  rd_data_o
);

  logic signed [W_WIDTH-1:0] mem_q [N_SYN];

  // Storage: the range guard matters when N_SYN is not a power of two and the
  // address bus can name rows that do not exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SYN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (int'(wr_addr_i) < N_SYN)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read is combinational from the registers, so a write in the same cycle is
  // not visible until the following cycle.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/izh_synaptic_current.sv
// Synaptic current stage feeding the Izhikevich neuron.
// Each timestep: decay the stored current, add the weights of synapses that
// spiked (one synapse per clock through a single adder), then add a bias.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   step_start     : one-cycle pulse that begins a timestep (accepted only when idle)
//   pre_spike      : presynaptic spikes, latched when a step is accepted
//   bias           : constant drive, sampled in the OUTPUT state
//   w_wr_en/addr/data : weight register file write port
//   input_current  : saturated current to the neuron, held between updates
//   current_valid  : one-cycle pulse when input_current is updated
//   busy           : high whenever a step is in flight
//   sat_flag       : sticky, set on any saturation
//   overrun        : sticky, set when step_start arrives while busy
module izh_synaptic_current
  import izh_pkg::*;
#(
  parameter int N_SYN       = 8,
  parameter int W_WIDTH     = izh_pkg::W_WIDTH,
  parameter int I_WIDTH     = izh_pkg::I_WIDTH,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step_start,
  input  logic [N_SYN-1:0]           pre_spike,
  input  logic signed [I_WIDTH-1:0]  bias,
  input  logic                       w_wr_en,
  input  logic [$clog2(N_SYN)-1:0]   w_wr_addr,
  input  logic signed [W_WIDTH-1:0]  w_wr_data,
  output logic signed [I_WIDTH-1:0]  input_current,
  output logic                       current_valid,
  output logic                       busy,
  output logic                       sat_flag,
  output logic                       overrun
);

  localparam int AW = $clog2(N_SYN);
  localparam int SW = I_WIDTH + 2;
  localparam logic [AW-1:0] K_LAST = AW'(N_SYN - 1);

  izh_state_e                state_q;
  logic [AW-1:0]             k_q;
  logic [N_SYN-1:0]          spk_q;
  logic signed [I_WIDTH-1:0] acc_q;
  logic signed [I_WIDTH-1:0] iSyn_q;
  logic signed [I_WIDTH-1:0] current_q;
  logic                      valid_q;
  logic                      sat_q;
  logic                      overrun_q;

  logic signed [W_WIDTH-1:0] weight;
  logic signed [I_WIDTH-1:0] decayStep_d;
  logic signed [I_WIDTH-1:0] decayAcc_d;
  logic signed [SW-1:0]      accSum_d;
  logic signed [SW-1:0]      biasSum_d;
  logic signed [I_WIDTH-1:0] accSat_d;
  logic signed [I_WIDTH-1:0] outSat_d;
  logic                      accClamp_d;
  logic                      biasClamp_d;

  izh_weight_rf #(
    .N_SYN   (N_SYN),
    .W_WIDTH (W_WIDTH)
  ) u_weights (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (w_wr_addr),
    .wr_data_i (w_wr_data),
    .rd_addr_i (k_q),
    .rd_data_o (weight)
  );

  // Shared arithmetic: decay amount, the per-synapse add and the bias add.
  // A positive current too small to shift down still loses one unit per step,
  // otherwise it would never return to zero.
  always_comb begin
    decayStep_d = iSyn_q >>> DECAY_SHIFT;
    if ((decayStep_d == '0) && !iSyn_q[I_WIDTH-1] && (iSyn_q != '0)) begin
      decayStep_d = I_WIDTH'(1);
    end
    decayAcc_d  = iSyn_q - decayStep_d;
    accSum_d    = SW'(acc_q) + SW'(weight);
    biasSum_d   = SW'(acc_q) + SW'(bias);
    accSat_d    = I_WIDTH'(sat_i(32'(accSum_d), I_WIDTH, accClamp_d));
    outSat_d    = I_WIDTH'(sat_i(32'(biasSum_d), I_WIDTH, biasClamp_d));
  end

  // Step sequencer: IDLE -> DECAY -> ACCUM x N_SYN -> OUTPUT -> IDLE.
  // A step_start seen outside IDLE only raises overrun; the step in flight
  // carries on untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      spk_q     <= '0;
      acc_q     <= '0;
      iSyn_q    <= '0;
      current_q <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (step_start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (step_start) begin
            spk_q   <= pre_spike;
            state_q <= DECAY;
          end
        end
        DECAY: begin
          acc_q   <= decayAcc_d;
          k_q     <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          if (spk_q[k_q]) begin
            acc_q <= accSat_d;
            if (accClamp_d) begin
              sat_q <= 1'b1;
            end
          end
          if (k_q == K_LAST) begin
            state_q <= OUTPUT;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        OUTPUT: begin
          iSyn_q    <= acc_q;
          current_q <= outSat_d;
          valid_q   <= 1'b1;
          if (biasClamp_d) begin
            sat_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign input_current = current_q;
  assign current_valid = valid_q;
  assign busy          = (state_q != IDLE);
  assign sat_flag      = sat_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_izh_synaptic_current.sv
// Self-checking bench for izh_synaptic_current: directed steps, a behavioural
// model that predicts each step's current into a queue, and a checker that pops
// the queue whenever the design reports current_valid.
module tb_izh_synaptic_current;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              step_start = 1'b0;
  logic [N-1:0]      pre_spike = '0;
  logic signed [15:0] bias = '0;
  logic              w_wr_en = 1'b0;
  logic [2:0]        w_wr_addr = '0;
  logic signed [7:0] w_wr_data = '0;
  logic signed [15:0] input_current;
  logic              current_valid;
  logic              busy;
  logic              sat_flag;
  logic              overrun;

  // Second, smaller instance whose address bus can name missing rows.
  logic              step2 = 1'b0;
  logic [4:0]        pre2 = '0;
  logic              wen2 = 1'b0;
  logic [2:0]        waddr2 = '0;
  logic signed [7:0] wdata2 = '0;
  logic signed [15:0] cur2;
  logic              valid2;
  logic              busy2;
  logic              sat2;
  logic              ovr2;

  int checks = 0;
  int failures = 0;

  int mISyn = 0;
  int mW [N];
  bit mSat = 1'b0;
  bit mOverrun = 1'b0;
  int expQ [$];

  always #5 clk = ~clk;

  izh_synaptic_current dut (
    .clk           (clk),
    .reset         (reset),
    .step_start    (step_start),
    .pre_spike     (pre_spike),
    .bias          (bias),
    .w_wr_en       (w_wr_en),
    .w_wr_addr     (w_wr_addr),
    .w_wr_data     (w_wr_data),
    .input_current (input_current),
    .current_valid (current_valid),
    .busy          (busy),
    .sat_flag      (sat_flag),
    .overrun       (overrun)
  );

  izh_synaptic_current #(.N_SYN(5)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .step_start    (step2),
    .pre_spike     (pre2),
    .bias          (16'sd0),
    .w_wr_en       (wen2),
    .w_wr_addr     (waddr2),
    .w_wr_data     (wdata2),
    .input_current (cur2),
    .current_valid (valid2),
    .busy          (busy2),
    .sat_flag      (sat2),
    .overrun       (ovr2)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int satModel(input int v);
    if (v > 32767) begin
      mSat = 1'b1;
      return 32767;
    end
    if (v < -32768) begin
      mSat = 1'b1;
      return -32768;
    end
    return v;
  endfunction

  // One timestep of the reference model; updates the model's stored current.
  task automatic modelStep(input logic [N-1:0] spikes, input int b, output int cur);
    int d;
    int acc;
    d = mISyn >>> 3;
    if (d == 0 && mISyn > 0) d = 1;
    acc = mISyn - d;
    for (int k = 0; k < N; k++) begin
      if (spikes[k]) acc = satModel(acc + mW[k]);
    end
    mISyn = acc;
    cur = satModel(acc + b);
  endtask

  task automatic modelReset();
    mISyn = 0;
    mSat = 1'b0;
    mOverrun = 1'b0;
    foreach (mW[i]) mW[i] = 0;
    expQ.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic writeWeight(input int addr, input int data);
    @(negedge clk);
    w_wr_en = 1'b1;
    w_wr_addr = 3'(addr);
    w_wr_data = 8'(data);
    @(negedge clk);
    w_wr_en = 1'b0;
    mW[addr] = data;
  endtask

  // Launches one step and watches N+8 cycles. Offsets count cycles after the
  // step_start cycle: pulseAt re-pulses step_start, resetAt pulses reset,
  // wrAt writes wrAddr/wrData (only used at or after that index is read).
  task automatic applyStimulus(input string tag, input logic [N-1:0] spikes,
                               input int pulseAt, input int resetAt, input int wrAt,
                               input logic [2:0] wrAddr, input logic signed [7:0] wrData);
    int cur;
    int nValid;
    nValid = 0;
    if (resetAt < 0) begin
      modelStep(spikes, int'(bias), cur);
      expQ.push_back(cur);
    end
    if (pulseAt > 0) mOverrun = 1'b1;
    @(negedge clk);
    pre_spike = spikes;
    step_start = 1'b1;
    for (int off = 1; off <= N + 8; off++) begin
      @(negedge clk);
      step_start = (off == pulseAt);
      pre_spike = ~spikes;
      reset = (off == resetAt);
      w_wr_en = (off == wrAt);
      w_wr_addr = wrAddr;
      w_wr_data = wrData;
      if (current_valid) begin
        nValid++;
        checkOutput({tag, "_latency"}, off, N + 3);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $error("[TB] FAIL %s unexpected current_valid observed=%0d expected=none",
                 tag, input_current);
        end else begin
          checkOutput(tag, input_current, expQ.pop_front());
        end
      end
    end
    checkOutput({tag, "_valid_count"}, nValid, (resetAt < 0) ? 1 : 0);
    if (wrAt > 0) mW[wrAddr] = wrData;
    if (resetAt > 0) modelReset();
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_sat_flag"}, sat_flag, mSat);
    checkOutput({tag, "_overrun"}, overrun, mOverrun);
  endtask

  initial begin
    int n2;
    foreach (mW[i]) mW[i] = 0;
    resetDut();
    checkOutput("rst_current", input_current, 0);
    checkOutput("rst_valid", current_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sat", sat_flag, 0);
    checkOutput("rst_overrun", overrun, 0);

    // Basic step: 0 + 10 - 4 = 6
    writeWeight(0, 10);
    writeWeight(1, -4);
    applyStimulus("basic", 8'b0000_0011, -1, -1, -1, 3'd0, 8'sd0);

    // Decay with the forced minimum of one: 5, 4, 3
    for (int i = 0; i < 3; i++) applyStimulus("decay_pos", 8'h00, -1, -1, -1, 3'd0, 8'sd0);
    // Drive negative: 2 - 8 = -6, then -5, then -4
    writeWeight(2, -8);
    applyStimulus("to_neg", 8'b0000_0100, -1, -1, -1, 3'd0, 8'sd0);
    for (int i = 0; i < 2; i++) applyStimulus("decay_neg", 8'h00, -1, -1, -1, 3'd0, 8'sd0);

    // Positive saturation
    for (int k = 0; k < N; k++) writeWeight(k, 127);
    bias = 16'sh7FFF;
    for (int i = 0; i < 3; i++) applyStimulus("sat_pos", 8'hFF, -1, -1, -1, 3'd0, 8'sd0);
    // Negative saturation
    for (int k = 0; k < N; k++) writeWeight(k, -128);
    bias = 16'sh8000;
    for (int i = 0; i < 4; i++) applyStimulus("sat_neg", 8'hFF, -1, -1, -1, 3'd0, 8'sd0);

    // Reset clears sticky flags, current and weights
    resetDut();
    checkOutput("rst2_sat", sat_flag, 0);
    checkOutput("rst2_current", input_current, 0);
    bias = '0;

    // Overrun: second pulse two cycles in is ignored
    writeWeight(0, 10);
    writeWeight(1, -4);
    applyStimulus("overrun", 8'b0000_0011, 2, -1, -1, 3'd0, 8'sd0);

    // Reset in the middle of ACCUM aborts the step
    applyStimulus("abort", 8'b0000_0011, -1, 4, -1, 3'd0, 8'sd0);
    checkOutput("abort_current", input_current, 0);
    writeWeight(0, 10);
    writeWeight(1, -4);
    applyStimulus("after_abort", 8'b0000_0011, -1, -1, -1, 3'd0, 8'sd0);

    // Write to w[1] in the cycle ACCUM reads it: old value now, new value next step
    applyStimulus("wr_same_cycle", 8'b0000_0011, -1, -1, 3, 3'd1, 8'sd50);
    applyStimulus("wr_next_step", 8'b0000_0011, -1, -1, -1, 3'd0, 8'sd0);

    // Out-of-range addresses on a 5-synapse instance leave the weights alone
    resetDut();
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      wen2 = 1'b1;
      waddr2 = 3'(a);
      wdata2 = (a < 5) ? 8'(a + 1) : 8'sd100;
    end
    @(negedge clk);
    wen2 = 1'b0;
    pre2 = 5'h1F;
    step2 = 1'b1;
    @(negedge clk);
    step2 = 1'b0;
    n2 = 0;
    while (!valid2 && n2 < 20) begin
      @(negedge clk);
      n2++;
    end
    checkOutput("oob_valid_seen", valid2, 1);
    checkOutput("oob_current", cur2, 15);
    @(negedge clk);
    checkOutput("oob_busy", busy2, 0);
    checkOutput("oob_sat", sat2, 0);
    checkOutput("oob_overrun", ovr2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
